// File: rtl/util_stream_pkg.sv
// Shared types and constants for the stream checker and its helpers.
package util_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLAG_W      = 5;
  localparam int ERR_DATA    = 0;
  localparam int ERR_KEEP    = 1;
  localparam int ERR_LEN     = 2;
  localparam int ERR_DEST    = 3;
  localparam int ERR_TIMEOUT = 4;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/util_stream_checker_if.sv
// AXI-Stream bundle; the checker sits on the slave side.
interface util_stream_checker_if #(
  parameter int TBYTE_NUM  = 16,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  logic                   tvalid;
  logic                   tready;
  logic [TBYTE_NUM*8-1:0] tdata;
  logic [TBYTE_NUM-1:0]   tkeep;
  logic                   tlast;
  logic [ID_WIDTH-1:0]    tid;
  logic [DEST_WIDTH-1:0]  tdest;

  modport master (output tvalid, tdata, tkeep, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tid, tdest, output tready);
endinterface

// File: rtl/util_stream_ready_gen.sv
// Back-pressure generator: tready drops for ready_gap cycles after each accepted beat.
module util_stream_ready_gen (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [31:0] ready_gap,
  input  logic        accept,
  output logic        tready
);

  logic [31:0] gap_cnt_reg;

  // Reload on every accepted beat, count down to zero, hold at zero while disabled.
  always_ff @(posedge clk) begin
    if (!rstn || !enable) begin
      gap_cnt_reg <= '0;
    end else if (accept) begin
      gap_cnt_reg <= ready_gap;
    end else if (gap_cnt_reg != 32'd0) begin
      gap_cnt_reg <= gap_cnt_reg - 32'd1;
    end
  end

  // Purely registered decision; never looks at tvalid.
  assign tready = rstn && enable && (gap_cnt_reg == 32'd0);

endmodule

// File: rtl/util_stream_checker.sv
// Stream sink that checks pattern-generator traffic and reports counts and first data error.
module util_stream_checker
  import util_stream_pkg::*;
#(
  parameter int TBYTE_NUM  = 16,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [DEST_WIDTH-1:0]  exp_dest,
  input  logic [31:0]            pkt_num,
  input  logic [31:0]            trans_len,
  input  logic [31:0]            ready_gap,
  input  logic [31:0]            timeout,
  input  logic [TBYTE_NUM*8-1:0] start_from,
  input  logic [TBYTE_NUM*8-1:0] inc,
  input  logic                   fix,
  input  logic                   check_start,
  output logic                   check_busy,
  output logic                   check_done,
  util_stream_checker_if.slave   s_axis,
  output logic [31:0]            beat_cnt,
  output logic [31:0]            pkt_cnt,
  output logic [31:0]            err_cnt,
  output logic [FLAG_W-1:0]      err_flags,
  output logic [TBYTE_NUM*8-1:0] first_err_data,
  output logic [TBYTE_NUM*8-1:0] first_err_exp
);

  localparam int DW = TBYTE_NUM * 8;

  state_t state_reg, state_next;

  logic [DEST_WIDTH-1:0] exp_dest_reg;
  logic [31:0]           pkt_num_reg, trans_len_reg, ready_gap_reg, timeout_reg;
  logic [DW-1:0]         start_from_reg, inc_reg;
  logic                  fix_reg;

  logic [DW-1:0]         exp_data_reg;
  logic [31:0]           beat_idx_reg, idle_cnt_reg;
  logic [31:0]           beat_cnt_reg, pkt_cnt_reg, err_cnt_reg;
  logic [FLAG_W-1:0]     err_flags_reg;
  logic [DW-1:0]         first_err_data_reg, first_err_exp_reg;

  logic                  ready, in_run, start_ok, accept, last_pkt, timeout_hit;
  logic [DW-1:0]         exp_word;
  logic [31:0]           idx_plus, pkt_cnt_inc, idle_cnt_inc;
  logic [FLAG_W-1:0]     beat_err;

  assign in_run       = (state_reg == ST_RUN);
  assign start_ok     = (state_reg == ST_IDLE) && check_start &&
                        (pkt_num != 32'd0) && (trans_len != 32'd0);
  assign accept       = in_run && s_axis.tvalid && ready;
  assign exp_word     = fix_reg ? start_from_reg : exp_data_reg;
  assign idx_plus     = sat_inc(beat_idx_reg);
  assign pkt_cnt_inc  = sat_inc(pkt_cnt_reg);
  assign idle_cnt_inc = sat_inc(idle_cnt_reg);
  assign last_pkt     = accept && s_axis.tlast && (pkt_cnt_inc == pkt_num_reg);
  assign timeout_hit  = in_run && !accept && (timeout_reg != 32'd0) &&
                        (idle_cnt_inc == timeout_reg);

  util_stream_ready_gen u_ready_gen (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (in_run),
    .ready_gap (ready_gap_reg),
    .accept    (accept),
    .tready    (ready)
  );

  assign s_axis.tready = ready;

  // Per-beat error classification against registered expectations.
  always_comb begin
    beat_err           = '0;
    beat_err[ERR_DATA] = (s_axis.tdata != exp_word);
    beat_err[ERR_KEEP] = (s_axis.tkeep != {TBYTE_NUM{1'b1}});
    beat_err[ERR_LEN]  = s_axis.tlast ? (idx_plus != trans_len_reg)
                                      : (idx_plus == trans_len_reg);
    beat_err[ERR_DEST] = (s_axis.tdest != exp_dest_reg);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // FSM next state: a run ends on the final packet's tlast or on an idle timeout.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (start_ok) state_next = ST_RUN;
      ST_RUN:  if (last_pkt || timeout_hit) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Configuration latch, counters, sticky flags and first-error capture.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      exp_dest_reg       <= '0;
      pkt_num_reg        <= '0;
      trans_len_reg      <= '0;
      ready_gap_reg      <= '0;
      timeout_reg        <= '0;
      start_from_reg     <= '0;
      inc_reg            <= '0;
      fix_reg            <= 1'b0;
      exp_data_reg       <= '0;
      beat_idx_reg       <= '0;
      idle_cnt_reg       <= '0;
      beat_cnt_reg       <= '0;
      pkt_cnt_reg        <= '0;
      err_cnt_reg        <= '0;
      err_flags_reg      <= '0;
      first_err_data_reg <= '0;
      first_err_exp_reg  <= '0;
    end else if (start_ok) begin
      exp_dest_reg       <= exp_dest;
      pkt_num_reg        <= pkt_num;
      trans_len_reg      <= trans_len;
      ready_gap_reg      <= ready_gap;
      timeout_reg        <= timeout;
      start_from_reg     <= start_from;
      inc_reg            <= inc;
      fix_reg            <= fix;
      exp_data_reg       <= start_from;
      beat_idx_reg       <= '0;
      idle_cnt_reg       <= '0;
      beat_cnt_reg       <= '0;
      pkt_cnt_reg        <= '0;
      err_cnt_reg        <= '0;
      err_flags_reg      <= '0;
      first_err_data_reg <= '0;
      first_err_exp_reg  <= '0;
    end else if (in_run) begin
      if (accept) begin
        beat_cnt_reg  <= sat_inc(beat_cnt_reg);
        idle_cnt_reg  <= '0;
        // Follow the received word so a single bad beat only costs two data errors.
        exp_data_reg  <= s_axis.tdata + inc_reg;
        beat_idx_reg  <= s_axis.tlast ? 32'd0 : idx_plus;
        err_flags_reg <= err_flags_reg | beat_err;
        if (s_axis.tlast) pkt_cnt_reg <= pkt_cnt_inc;
        if (|beat_err) err_cnt_reg <= sat_inc(err_cnt_reg);
        if (beat_err[ERR_DATA] && !err_flags_reg[ERR_DATA]) begin
          first_err_data_reg <= s_axis.tdata;
          first_err_exp_reg  <= exp_word;
        end
      end else begin
        idle_cnt_reg <= idle_cnt_inc;
        if (timeout_hit) err_flags_reg[ERR_TIMEOUT] <= 1'b1;
      end
    end
  end

  assign check_busy     = in_run;
  assign check_done     = (state_reg == ST_DONE);
  assign beat_cnt       = beat_cnt_reg;
  assign pkt_cnt        = pkt_cnt_reg;
  assign err_cnt        = err_cnt_reg;
  assign err_flags      = err_flags_reg;
  assign first_err_data = first_err_data_reg;
  assign first_err_exp  = first_err_exp_reg;

endmodule
